rf_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (RegWEn/rd/mux_out) between NREQ writeback requesters
//  (ALU, load unit, UART RX, CSR). Round-robin arbitration; one registered output stage driving the write port.

---
 rtl/rf_wb_arbiter.sv | 129 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback sources, with one registered stage.
// Optional RF_WB_BYPASS_EN forwards the in-flight write to decode reads instead of flagging RAW hazards.
module rf_wb_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 RegWEn,
  output logic [AW-1:0]        rd,
  output logic [DW-1:0]        mux_out,
  input  logic [AW-1:0]        rs1,
  input  logic [AW-1:0]        rs2,
  input  logic [DW-1:0]        rf_data_R1,
  input  logic [DW-1:0]        rf_data_R2,
  output logic [DW-1:0]        data_R1,
  output logic [DW-1:0]        data_R2,
  output logic                 hz_rs1,
  output logic                 hz_rs2,
  output logic [CNT_W-1:0]     conflict_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             wen_q, wen_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [DW-1:0]    data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0]  grant;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    idx;
  logic             any_vld;
  logic             multi_vld;
  logic [AW-1:0]    win_rd;
  logic [DW-1:0]    win_data;
  logic             match_1, match_2;

  logic [AW-1:0]    rd_arr   [NREQ];
  logic [DW-1:0]    data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign rd_arr[g]   = req_rd[g*AW +: AW];
    assign data_arr[g] = req_data[g*DW +: DW];
  end

  // Search begins one past the last winner, so the last winner has lowest priority.
  always_comb begin
    grant   = '0;
    win_idx = rr_ptr_q;
    idx     = '0;
    any_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(rr_ptr_q) + k) % NREQ);
      if (!any_vld && req_valid[idx]) begin
        any_vld    = 1'b1;
        win_idx    = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  assign req_ready = cpu_rst ? '0 : grant;
  assign win_rd    = rd_arr[win_idx];
  assign win_data  = data_arr[win_idx];
  assign multi_vld = |(req_valid & (req_valid - 1'b1));

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    rd_d     = rd_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    // Writes to x0 are consumed but never reach the register file.
    wen_d    = any_vld && (win_rd != '0);
    if (any_vld) begin
      rr_ptr_d = win_idx;
      rd_d     = win_rd;
      data_d   = win_data;
    end
    if (multi_vld && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      rr_ptr_q <= PW'(NREQ - 1);
      wen_q    <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wen_q    <= wen_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign RegWEn       = wen_q;
  assign rd           = rd_q;
  assign mux_out      = data_q;
  assign conflict_cnt = cnt_q;

  // The registered write has not landed in reg_file yet; rd_q != 0 also excludes rs==0.
  assign match_1 = wen_q && (rd_q != '0) && (rs1 == rd_q);
  assign match_2 = wen_q && (rd_q != '0) && (rs2 == rd_q);

`ifdef RF_WB_BYPASS_EN
  assign data_R1 = match_1 ? data_q : rf_data_R1;
  assign data_R2 = match_2 ? data_q : rf_data_R2;
  assign hz_rs1  = 1'b0;
  assign hz_rs2  = 1'b0;
`else
  assign data_R1 = rf_data_R1;
  assign data_R2 = rf_data_R2;
  assign hz_rs1  = match_1;
  assign hz_rs2  = match_2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter built with CNT_W=4 so counter saturation is reachable quickly.
module tb_rf_wb_arbiter;

  localparam int NREQ = 4;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CNT_W = 4;

  logic                 cpu_clk = 1'b0;
  logic                 cpu_rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_rd = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic                 RegWEn;
  logic [AW-1:0]        rd;
  logic [DW-1:0]        mux_out;
  logic [AW-1:0]        rs1 = '0;
  logic [AW-1:0]        rs2 = '0;
  logic [DW-1:0]        rf_data_R1 = '0;
  logic [DW-1:0]        rf_data_R2 = '0;
  logic [DW-1:0]        data_R1, data_R2;
  logic                 hz_rs1, hz_rs2;
  logic [CNT_W-1:0]     conflict_cnt;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  rf_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd), .req_data(req_data),
    .RegWEn(RegWEn), .rd(rd), .mux_out(mux_out),
    .rs1(rs1), .rs2(rs2), .rf_data_R1(rf_data_R1), .rf_data_R2(rf_data_R2),
    .data_R1(data_R1), .data_R2(data_R2), .hz_rs1(hz_rs1), .hz_rs2(hz_rs2),
    .conflict_cnt(conflict_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
    req_rd[i*AW +: AW]   = r;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic bump_cnt();
    if (exp_cnt < 15) exp_cnt++;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), DW'(32'hA0 + i));
    #12;
    tests++; if (RegWEn !== 1'b0) begin fails++; $display("FAIL rst_wen: got %0b want 0", RegWEn); end
    tests++; if (rd !== '0) begin fails++; $display("FAIL rst_rd: got %0h want 0", rd); end
    tests++; if (mux_out !== '0) begin fails++; $display("FAIL rst_data: got %0h want 0", mux_out); end
    tests++; if (conflict_cnt !== '0) begin fails++; $display("FAIL rst_cnt: got %0h want 0", conflict_cnt); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
  endtask

  task automatic test_round_robin();
    step();
    cpu_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (req_ready !== 4'(1 << (i % 4))) begin fails++; $display("FAIL rr_ready%0d: got %b want %b", i, req_ready, 4'(1 << (i % 4))); end
      step();
      bump_cnt();
      tests++; if (RegWEn !== 1'b1) begin fails++; $display("FAIL rr_wen%0d: got %0b want 1", i, RegWEn); end
      tests++; if (rd !== AW'(i % 4 + 1)) begin fails++; $display("FAIL rr_rd%0d: got %0d want %0d", i, rd, i % 4 + 1); end
      tests++; if (mux_out !== DW'(32'hA0 + i % 4)) begin fails++; $display("FAIL rr_data%0d: got %0h want %0h", i, mux_out, 32'hA0 + i % 4); end
      tests++; if (conflict_cnt !== CNT_W'(exp_cnt)) begin fails++; $display("FAIL rr_cnt%0d: got %0d want %0d", i, conflict_cnt, exp_cnt); end
    end
  endtask

  task automatic test_x0_and_pointer();
    req_valid = 4'b0100;
    set_req(2, '0, 32'hDEAD);
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL x0_ready: got %b want 0100", req_ready); end
    step();
    tests++; if (RegWEn !== 1'b0) begin fails++; $display("FAIL x0_wen: got %0b want 0", RegWEn); end
    tests++; if (rd !== '0) begin fails++; $display("FAIL x0_rd: got %0h want 0", rd); end
    tests++; if (mux_out !== 32'hDEAD) begin fails++; $display("FAIL x0_data: got %0h want dead", mux_out); end
    tests++; if (conflict_cnt !== CNT_W'(exp_cnt)) begin fails++; $display("FAIL x0_cnt: got %0d want %0d", conflict_cnt, exp_cnt); end
    req_valid = 4'b1010;
    set_req(3, 5'd9, 32'h33);
    #1;
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL ptr_ready: got %b want 1000", req_ready); end
    step();
    bump_cnt();
    tests++; if (RegWEn !== 1'b1 || rd !== 5'd9 || mux_out !== 32'h33) begin fails++; $display("FAIL ptr_write: got wen=%0b rd=%0d data=%0h want 1/9/33", RegWEn, rd, mux_out); end
    tests++; if (conflict_cnt !== CNT_W'(exp_cnt)) begin fails++; $display("FAIL ptr_cnt: got %0d want %0d", conflict_cnt, exp_cnt); end
    req_valid = 4'b0000;
    #1;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL idle_ready: got %b want 0000", req_ready); end
    step();
    tests++; if (RegWEn !== 1'b0 || rd !== 5'd9 || mux_out !== 32'h33) begin fails++; $display("FAIL idle_hold: got wen=%0b rd=%0d data=%0h want 0/9/33", RegWEn, rd, mux_out); end
  endtask

  task automatic test_hazard();
    logic [DW-1:0] exp_d;
    logic          exp_hz;
    req_valid = 4'b0010;
    set_req(1, 5'd7, 32'h1234);
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL hz_ready: got %b want 0010", req_ready); end
    step();
    req_valid = 4'b0000;
    rs1 = 5'd7; rs2 = 5'd7; rf_data_R1 = '0; rf_data_R2 = '0;
`ifdef RF_WB_BYPASS_EN
    exp_d = 32'h1234; exp_hz = 1'b0;
`else
    exp_d = 32'h0; exp_hz = 1'b1;
`endif
    #1;
    tests++; if (data_R1 !== exp_d || data_R2 !== exp_d) begin fails++; $display("FAIL hz_data: got %0h/%0h want %0h", data_R1, data_R2, exp_d); end
    tests++; if (hz_rs1 !== exp_hz || hz_rs2 !== exp_hz) begin fails++; $display("FAIL hz_flags: got %0b%0b want %0b%0b", hz_rs1, hz_rs2, exp_hz, exp_hz); end
    rs1 = '0; rf_data_R1 = 32'h5555;
    #1;
    tests++; if (hz_rs1 !== 1'b0 || data_R1 !== 32'h5555) begin fails++; $display("FAIL hz_rs0: got hz=%0b data=%0h want 0/5555", hz_rs1, data_R1); end
    tests++; if (hz_rs2 !== exp_hz || data_R2 !== exp_d) begin fails++; $display("FAIL hz_rs2_keep: got hz=%0b data=%0h want %0b/%0h", hz_rs2, data_R2, exp_hz, exp_d); end
    step();
    tests++; if (hz_rs2 !== 1'b0 || data_R2 !== 32'h0) begin fails++; $display("FAIL hz_idle: got hz=%0b data=%0h want 0/0", hz_rs2, data_R2); end
  endtask

  task automatic test_async_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), DW'(32'hA0 + i));
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL ar_ready_pre: got %b want 0100", req_ready); end
    step();
    bump_cnt();
    tests++; if (RegWEn !== 1'b1 || rd !== 5'd3) begin fails++; $display("FAIL ar_pre: got wen=%0b rd=%0d want 1/3", RegWEn, rd); end
    #2;
    cpu_rst = 1'b1;
    exp_cnt = 0;
    #1;
    tests++; if (RegWEn !== 1'b0 || rd !== '0 || mux_out !== '0) begin fails++; $display("FAIL ar_outs: got wen=%0b rd=%0d data=%0h want 0/0/0", RegWEn, rd, mux_out); end
    tests++; if (req_ready !== 4'b0000 || conflict_cnt !== '0) begin fails++; $display("FAIL ar_ready: got rdy=%b cnt=%0d want 0000/0", req_ready, conflict_cnt); end
    step();
    cpu_rst = 1'b0;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL ar_first: got %b want 0001", req_ready); end
    step();
    bump_cnt();
    tests++; if (RegWEn !== 1'b1 || rd !== 5'd1 || conflict_cnt !== CNT_W'(exp_cnt)) begin fails++; $display("FAIL ar_post: got wen=%0b rd=%0d cnt=%0d want 1/1/%0d", RegWEn, rd, conflict_cnt, exp_cnt); end
  endtask

  task automatic test_saturation();
    req_valid = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      step();
      bump_cnt();
      tests++; if (conflict_cnt !== CNT_W'(exp_cnt)) begin fails++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, conflict_cnt, exp_cnt); end
    end
    tests++; if (conflict_cnt !== 4'hF) begin fails++; $display("FAIL sat_final: got %0h want f", conflict_cnt); end
    req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_x0_and_pointer();
    test_hazard();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
